// File: rtl/sdr_port_arbiter.sv
// Round-robin ingress-port arbiter and auto-refresh scheduler placed in front of
// the SDR SDRAM command sequencer.
module sdr_port_arbiter #(
    parameter int          nr_of_ports = 4,
    parameter logic [15:0] rfr_length  = 16'd390
) (
    input  logic                   sdram_clk,
    input  logic                   sdram_rst,
    input  logic [nr_of_ports-1:0] port_empty,
    input  logic                   state_idle,
    input  logic                   fifo_rd_adr,
    input  logic                   fifo_rd_data,
    input  logic                   cmd_aref,
    output logic                   fifo_empty,
    output logic [nr_of_ports-1:0] fifo_sel,
    output logic [nr_of_ports-1:0] port_rd_adr,
    output logic [nr_of_ports-1:0] port_rd_data,
    output logic                   refresh_req,
    output logic                   rfr_overflow
);

    localparam int idx_w = $clog2(nr_of_ports);

    function automatic logic [idx_w-1:0] onehot_to_idx(input logic [nr_of_ports-1:0] oh);
        logic [idx_w-1:0] idx;
        idx = '0;
        for (int i = 0; i < nr_of_ports; i++) begin
            if (oh[i]) begin
                idx = idx_w'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [nr_of_ports-1:0] fifo_sel_r;
    logic                   served_r;
    logic [idx_w-1:0]       grant_idx_s;
    logic [nr_of_ports-1:0] next_sel_s;
    logic                   rotate_s;
    logic [15:0]            rfr_cnt_r;
    logic                   tick_s;
    logic [1:0]             owed_r;
    logic [1:0]             owed_next_s;
    logic                   rfr_overflow_r;
    logic                   overflow_next_s;

    assign grant_idx_s = onehot_to_idx(fifo_sel_r);

    // A just-served grant must hand over even if its FIFO still holds data.
    assign rotate_s = state_idle & (served_r | port_empty[grant_idx_s]);

    // Search the ports after the current grant for the first non-empty one.
    always_comb begin
        logic             found_s;
        logic [idx_w-1:0] cand_s;
        next_sel_s = fifo_sel_r;
        found_s    = 1'b0;
        cand_s     = '0;
        for (int k = 1; k < nr_of_ports; k++) begin
            cand_s = idx_w'((int'(grant_idx_s) + k) % nr_of_ports);
            if (!found_s && !port_empty[cand_s]) begin
                next_sel_s         = '0;
                next_sel_s[cand_s] = 1'b1;
                found_s            = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Grant register and served flag.
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            fifo_sel_r <= {{(nr_of_ports-1){1'b0}}, 1'b1};
            served_r   <= 1'b0;
        end else if (rotate_s) begin
            fifo_sel_r <= next_sel_s;
            served_r   <= 1'b0;
        end else if (fifo_rd_adr) begin
            served_r   <= 1'b1;
        end else begin
            served_r   <= served_r;
        end
    end

    // Forcing empty right after a service keeps the sequencer in idle while the grant moves.
    assign fifo_empty   = port_empty[grant_idx_s] | (state_idle & served_r);
    assign fifo_sel     = fifo_sel_r;
    assign port_rd_adr  = fifo_sel_r & {nr_of_ports{fifo_rd_adr}};
    assign port_rd_data = fifo_sel_r & {nr_of_ports{fifo_rd_data}};

    assign tick_s = (rfr_cnt_r == (rfr_length - 16'd1));

    // Refresh interval counter.
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            rfr_cnt_r <= 16'd0;
        end else if (tick_s) begin
            rfr_cnt_r <= 16'd0;
        end else begin
            rfr_cnt_r <= rfr_cnt_r + 16'd1;
        end
    end

    // Owed-refresh bookkeeping; AREFs with nothing owed (init sequence) are ignored.
    always_comb begin
        owed_next_s     = owed_r;
        overflow_next_s = tick_s & ~cmd_aref & (owed_r == 2'd3);
        case ({tick_s, cmd_aref})
            2'b10:   owed_next_s = (owed_r == 2'd3) ? 2'd3 : owed_r + 2'd1;
            2'b01:   owed_next_s = (owed_r != 2'd0) ? owed_r - 2'd1 : owed_r;
            default: owed_next_s = owed_r;
        endcase
    end

    // Owed counter and overflow pulse registers.
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            owed_r         <= 2'd0;
            rfr_overflow_r <= 1'b0;
        end else begin
            owed_r         <= owed_next_s;
            rfr_overflow_r <= overflow_next_s;
        end
    end

    assign refresh_req  = (owed_r != 2'd0);
    assign rfr_overflow = rfr_overflow_r;

endmodule
